// File: rtl/layer_sequencer.sv
// Sequences one fully-connected layer over a shared MAC: per neuron it clears, accumulates K
// products, adds bias, runs the activation handshake and writes the result.
module layer_sequencer #(
  parameter int unsigned NUM_INPUTS  = 2,
  parameter int unsigned NUM_NEURONS = 2,
  parameter int unsigned IN_W        = 1,
  parameter int unsigned NEU_W       = 1,
  parameter int unsigned WA_W        = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  output logic             o_mac_req,
  input  logic             i_mac_ack,
  output logic             o_clr_acc,
  output logic [IN_W-1:0]  o_in_addr,
  output logic [WA_W-1:0]  o_w_addr,
  output logic             o_bias_en,
  output logic             o_act_req,
  input  logic             i_act_ack,
  output logic             o_wr_en,
  output logic [NEU_W-1:0] o_neuron_idx,
  output logic [NEU_W-1:0] o_wr_addr,
  output logic             o_busy,
  output logic             o_done
);

  if (NUM_INPUTS < 1 || NUM_NEURONS < 1) begin : g_bad_count
    $error("layer_sequencer: NUM_INPUTS and NUM_NEURONS must be at least 1");
  end
  if ((64'd1 << IN_W) < 64'(NUM_INPUTS) || (64'd1 << NEU_W) < 64'(NUM_NEURONS)) begin : g_bad_idx_w
    $error("layer_sequencer: IN_W/NEU_W too narrow for the layer size");
  end
  if ((64'd1 << WA_W) < 64'(NUM_INPUTS) * 64'(NUM_NEURONS)) begin : g_bad_wa_w
    $error("layer_sequencer: WA_W too narrow for NUM_INPUTS*NUM_NEURONS weights");
  end

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StMac,
    StBias,
    StAct,
    StWrite,
    StDone
  } state_e;

  localparam logic [IN_W-1:0]  LastIn  = IN_W'(NUM_INPUTS - 1);
  localparam logic [NEU_W-1:0] LastNeu = NEU_W'(NUM_NEURONS - 1);
  localparam logic [WA_W-1:0]  KWide   = WA_W'(NUM_INPUTS);

  state_e             r_state;
  state_e             w_state_next;
  logic [NEU_W-1:0]   r_nidx;
  logic [NEU_W-1:0]   w_nidx_next;
  logic [IN_W-1:0]    r_iidx;
  logic [IN_W-1:0]    w_iidx_next;

  // Falling-edge state update keeps this block in phase with the layer datapath.
  always_ff @(negedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_nidx  <= '0;
      r_iidx  <= '0;
    end else begin
      r_state <= w_state_next;
      r_nidx  <= w_nidx_next;
      r_iidx  <= w_iidx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_nidx_next  = r_nidx;
    w_iidx_next  = r_iidx;
    o_mac_req    = 1'b0;
    o_clr_acc    = 1'b0;
    o_bias_en    = 1'b0;
    o_act_req    = 1'b0;
    o_wr_en      = 1'b0;
    o_done       = 1'b0;
    o_busy       = 1'b1;
    unique case (r_state)
      StIdle: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_nidx_next  = '0;
          w_iidx_next  = '0;
          w_state_next = StClear;
        end
      end
      StClear: begin
        o_clr_acc    = 1'b1;
        w_state_next = StMac;
      end
      StMac: begin
        o_mac_req = 1'b1;
        if (i_mac_ack) begin
          if (r_iidx == LastIn) begin
            w_iidx_next  = '0;
            w_state_next = StBias;
          end else begin
            w_iidx_next = r_iidx + IN_W'(1);
          end
        end
      end
      StBias: begin
        o_bias_en    = 1'b1;
        w_state_next = StAct;
      end
      StAct: begin
        o_act_req = 1'b1;
        if (i_act_ack) begin
          w_state_next = StWrite;
        end
      end
      StWrite: begin
        o_wr_en = 1'b1;
        if (r_nidx == LastNeu) begin
          w_state_next = StDone;
        end else begin
          w_nidx_next  = r_nidx + NEU_W'(1);
          w_state_next = StClear;
        end
      end
      StDone: begin
        o_done       = 1'b1;
        w_state_next = StIdle;
      end
      default: begin
        o_busy       = 1'b0;
        w_state_next = StIdle;
      end
    endcase
  end

  assign o_in_addr    = r_iidx;
  assign o_neuron_idx = r_nidx;
  assign o_wr_addr    = r_nidx;
  assign o_w_addr     = WA_W'(r_nidx) * KWide + WA_W'(r_iidx);

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboarded random bench for layer_sequencer: a default 2x2 instance and a 3x4 instance,
// each checked against an event list derived from the layer size and the ack delays.
module tb_layer_sequencer;

  typedef struct packed {
    int kind;
    int in_a;
    int w_a;
    int n;
    int cyc;
  } ev_t;

  localparam int EvClr  = 0;
  localparam int EvMac  = 1;
  localparam int EvBias = 2;
  localparam int EvAct  = 3;
  localparam int EvWr   = 4;
  localparam int EvDone = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] start = '0;
  logic [1:0] mac_ack = '0;
  logic [1:0] act_ack = '0;
  logic [1:0] mac_req, clr_acc, bias_en, act_req, wr_en, busy, done;
  logic       d0_in, d0_nidx, d0_wr;
  logic [1:0] d0_w;
  logic [1:0] d1_in, d1_nidx, d1_wr;
  logic [3:0] d1_w;

  ev_t exp_q[2][$];
  int  mac_dly_q[2][$];
  int  act_dly_q[2][$];
  int  base[2];
  int  done_c[2];
  bit  has_run[2];
  int  mac_cnt[2];
  int  act_cnt[2];
  bit  mac_on[2];
  bit  act_on[2];
  int  neg_cnt = 0;
  int  ack_fill = 0;  // idle ack level: 0 low, 1 tied high, 2 random
  int  errors = 0;
  int  checks = 0;

  layer_sequencer u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]),
    .o_mac_req(mac_req[0]), .i_mac_ack(mac_ack[0]), .o_clr_acc(clr_acc[0]),
    .o_in_addr(d0_in), .o_w_addr(d0_w), .o_bias_en(bias_en[0]),
    .o_act_req(act_req[0]), .i_act_ack(act_ack[0]), .o_wr_en(wr_en[0]),
    .o_neuron_idx(d0_nidx), .o_wr_addr(d0_wr), .o_busy(busy[0]), .o_done(done[0])
  );

  layer_sequencer #(
    .NUM_INPUTS(4), .NUM_NEURONS(3), .IN_W(2), .NEU_W(2), .WA_W(4)
  ) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]),
    .o_mac_req(mac_req[1]), .i_mac_ack(mac_ack[1]), .o_clr_acc(clr_acc[1]),
    .o_in_addr(d1_in), .o_w_addr(d1_w), .o_bias_en(bias_en[1]),
    .o_act_req(act_req[1]), .i_act_ack(act_ack[1]), .o_wr_en(wr_en[1]),
    .o_neuron_idx(d1_nidx), .o_wr_addr(d1_wr), .o_busy(busy[1]), .o_done(done[1])
  );

  always #5 clk = ~clk;
  always @(negedge clk) neg_cnt <= neg_cnt + 1;

  function automatic int get_in(input int d);
    return (d == 0) ? int'(d0_in) : int'(d1_in);
  endfunction
  function automatic int get_w(input int d);
    return (d == 0) ? int'(d0_w) : int'(d1_w);
  endfunction
  function automatic int get_n(input int d);
    return (d == 0) ? int'(d0_nidx) : int'(d1_nidx);
  endfunction
  function automatic int get_wr(input int d);
    return (d == 0) ? int'(d0_wr) : int'(d1_wr);
  endfunction
  function automatic logic fill_val();
    return (ack_fill == 1) ? 1'b1 : (ack_fill == 2) ? logic'($urandom_range(0, 1)) : 1'b0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input int d);
    string p;
    p = $sformatf("dut%0d reset", d);
    chk({p, " mac_req"}, int'(mac_req[d]), 0);
    chk({p, " clr_acc"}, int'(clr_acc[d]), 0);
    chk({p, " bias_en"}, int'(bias_en[d]), 0);
    chk({p, " act_req"}, int'(act_req[d]), 0);
    chk({p, " wr_en"}, int'(wr_en[d]), 0);
    chk({p, " busy"}, int'(busy[d]), 0);
    chk({p, " done"}, int'(done[d]), 0);
    chk({p, " in_addr"}, get_in(d), 0);
    chk({p, " w_addr"}, get_w(d), 0);
    chk({p, " neuron_idx"}, get_n(d), 0);
    chk({p, " wr_addr"}, get_wr(d), 0);
  endtask

  function automatic ev_t mk(input int kind, input int in_a, input int w_a, input int n,
                             input int cyc);
    ev_t e;
    e.kind = kind;
    e.in_a = in_a;
    e.w_a  = w_a;
    e.n    = n;
    e.cyc  = cyc;
    return e;
  endfunction

  // Reference timeline: each neuron is CLEAR, K MACs (each stretched by its ack delay), BIAS,
  // ACT (stretched), WRITE; DONE follows the last neuron. Mode 0 no delay, 1 random, 2 directed.
  task automatic launch(input int d, input int mode);
    int nn, kk, t, dly;
    nn = (d == 0) ? 2 : 3;
    kk = (d == 0) ? 2 : 4;
    t  = 1;
    base[d]    = neg_cnt;
    has_run[d] = 1'b1;
    for (int n = 0; n < nn; n++) begin
      exp_q[d].push_back(mk(EvClr, 0, 0, n, t));
      t++;
      for (int i = 0; i < kk; i++) begin
        dly = (mode == 0) ? 0 : (mode == 1) ? int'($urandom_range(0, 3)) :
              ((n == 0 && i == 1) ? 3 : 0);
        mac_dly_q[d].push_back(dly);
        t += dly;
        exp_q[d].push_back(mk(EvMac, i, n * kk + i, n, t));
        t++;
      end
      exp_q[d].push_back(mk(EvBias, 0, 0, n, t));
      t++;
      dly = (mode == 0) ? 0 : (mode == 1) ? int'($urandom_range(0, 3)) : ((n == 0) ? 2 : 0);
      act_dly_q[d].push_back(dly);
      t += dly;
      exp_q[d].push_back(mk(EvAct, 0, 0, n, t));
      t++;
      exp_q[d].push_back(mk(EvWr, 0, 0, n, t));
      t++;
    end
    exp_q[d].push_back(mk(EvDone, 0, 0, nn - 1, t));
    done_c[d] = t;
    start[d]  = 1'b1;
  endtask

  task automatic wait_run(input int d, input bit spur_start);
    int budget, c;
    budget = 400;
    while (exp_q[d].size() != 0 && budget > 0) begin
      @(posedge clk);
      c = neg_cnt - base[d];
      start[d] = spur_start && c >= 1 && c <= done_c[d] && ($urandom_range(0, 3) == 0);
      budget--;
    end
    start[d] = 1'b0;
    chk($sformatf("dut%0d run finished within budget", d), int'(budget > 0), 1);
    if (budget == 0) begin
      exp_q[d].delete();
      has_run[d] = 1'b0;
    end
  endtask

  // Ack responder: answers each request after its planned delay, otherwise drives filler.
  initial forever begin
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mac_on[d] = 1'b0;
        act_on[d] = 1'b0;
        mac_dly_q[d].delete();
        act_dly_q[d].delete();
        mac_ack[d] = 1'b0;
        act_ack[d] = 1'b0;
      end else begin
        if (mac_req[d]) begin
          if (!mac_on[d]) begin
            mac_cnt[d] = (mac_dly_q[d].size() > 0) ? mac_dly_q[d].pop_front() : 0;
            mac_on[d]  = 1'b1;
          end
          if (mac_cnt[d] == 0) begin
            mac_ack[d] = 1'b1;
            mac_on[d]  = 1'b0;
          end else begin
            mac_ack[d] = 1'b0;
            mac_cnt[d]--;
          end
        end else begin
          mac_ack[d] = fill_val();
        end
        if (act_req[d]) begin
          if (!act_on[d]) begin
            act_cnt[d] = (act_dly_q[d].size() > 0) ? act_dly_q[d].pop_front() : 0;
            act_on[d]  = 1'b1;
          end
          if (act_cnt[d] == 0) begin
            act_ack[d] = 1'b1;
            act_on[d]  = 1'b0;
          end else begin
            act_ack[d] = 1'b0;
            act_cnt[d]--;
          end
        end else begin
          act_ack[d] = fill_val();
        end
      end
    end
  end

  // Monitor: pops one expected event per observed strobe/handshake.
  initial forever begin
    @(posedge clk);
    #3;
    for (int d = 0; d < 2; d++) begin
      int   c;
      int   eb;
      logic [5:0] fl;
      ev_t  e;
      c  = neg_cnt - base[d];
      eb = (has_run[d] && c >= 1 && c <= done_c[d]) ? 1 : 0;
      chk($sformatf("dut%0d busy c=%0d", d, c), int'(busy[d]), eb);
      fl = {done[d], wr_en[d], act_req[d] & act_ack[d], bias_en[d], mac_req[d] & mac_ack[d],
            clr_acc[d]};
      if (mac_req[d] && exp_q[d].size() > 0 && exp_q[d][0].kind == EvMac) begin
        chk($sformatf("dut%0d held in_addr c=%0d", d, c), get_in(d), exp_q[d][0].in_a);
        chk($sformatf("dut%0d held w_addr c=%0d", d, c), get_w(d), exp_q[d][0].w_a);
      end
      for (int k = 0; k < 6; k++) begin
        if (fl[k]) begin
          if (exp_q[d].size() == 0) begin
            chk($sformatf("dut%0d unexpected event kind c=%0d", d, c), k, -1);
          end else begin
            e = exp_q[d].pop_front();
            chk($sformatf("dut%0d event kind c=%0d", d, c), k, e.kind);
            chk($sformatf("dut%0d event cycle kind=%0d", d, k), c, e.cyc);
            chk($sformatf("dut%0d neuron_idx c=%0d", d, c), get_n(d), e.n);
            if (k == EvMac) begin
              chk($sformatf("dut%0d mac in_addr c=%0d", d, c), get_in(d), e.in_a);
              chk($sformatf("dut%0d mac w_addr c=%0d", d, c), get_w(d), e.w_a);
            end
            if (k == EvWr) begin
              chk($sformatf("dut%0d wr_addr c=%0d", d, c), get_wr(d), e.n);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    base    = '{0, 0};
    done_c  = '{0, 0};
    has_run = '{1'b0, 1'b0};
    mac_on  = '{1'b0, 1'b0};
    act_on  = '{1'b0, 1'b0};
    #7 rst = 1'b0;

    // Asynchronous reset between edges while idle, then a quiet stretch.
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_zero(0);
    check_zero(1);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);

    ack_fill = 1;
    launch(0, 0);
    wait_run(0, 1'b0);
    ack_fill = 0;
    @(posedge clk);
    launch(0, 2);
    wait_run(0, 1'b0);
    ack_fill = 2;
    @(posedge clk);
    launch(0, 0);
    wait_run(0, 1'b1);

    // Reset while the second neuron is accumulating.
    ack_fill = 1;
    @(posedge clk);
    launch(0, 0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      start[0] = 1'b0;
      #1;
      if (d0_nidx == 1'b1 && mac_req[0]) found = 1'b1;
    end
    chk("dut0 reached second neuron MAC", int'(found), 1);
    exp_q[0].delete();
    has_run[0] = 1'b0;
    rst = 1'b1;
    #1 check_zero(0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    launch(0, 0);
    wait_run(0, 1'b0);

    ack_fill = 2;
    repeat (4) begin
      @(posedge clk);
      launch(0, 1);
      wait_run(0, 1'b1);
    end

    // Larger layer, including a start in the cycle right after DONE.
    ack_fill = 1;
    @(posedge clk);
    launch(1, 0);
    wait_run(1, 1'b0);
    launch(1, 0);
    wait_run(1, 1'b0);
    ack_fill = 2;
    repeat (3) begin
      @(posedge clk);
      launch(1, 1);
      wait_run(1, 1'b1);
    end

    repeat (5) @(posedge clk);
    #4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
